// File: rtl/bitmap_iter_pkg.sv
// Shared constants and helpers for the bitmap iterator.
// No logic; state encodings and a constant clog2 used for parameter checks.
// Not applicable (package only).
package bitmap_iter_pkg;

    // Scanner state encoding (two bits, value 3 unused)
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Ceiling log2 evaluated at elaboration time
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bitmap_iter_ff_set.sv
// Find-first-set: lowest set bit index of vect_in via a BLOCK_WIDTH-ary tree.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the output follows the input every cycle.
module ff_set
    import bitmap_iter_pkg::*;
#(
    parameter int VECT_WIDTH     = 64,
    parameter int VECT_IND_WIDTH = 6,
    parameter int BLOCK_WIDTH    = 2
) (
    input  logic [VECT_WIDTH-1:0]     vect_in,
    output logic                      val_out,
    output logic [VECT_IND_WIDTH-1:0] ind_out
);

    // Index bits contributed by one tree level, and number of levels
    localparam int LB     = clog2(BLOCK_WIDTH);
    localparam int LEVELS = VECT_IND_WIDTH / LB;

    if ((1 << LB) != BLOCK_WIDTH) begin : g_bw_chk
        $error("ff_set: BLOCK_WIDTH must be a power of two");
    end
    if ((LEVELS * LB != VECT_IND_WIDTH) || ((1 << VECT_IND_WIDTH) != VECT_WIDTH)) begin : g_vw_chk
        $error("ff_set: VECT_WIDTH must be a power of BLOCK_WIDTH");
    end

    // Per-level node valid flags and partial indices; level 0 is the raw vector
    logic [VECT_WIDTH-1:0]     lvl_val [LEVELS+1];
    logic [VECT_IND_WIDTH-1:0] lvl_ind [LEVELS+1][VECT_WIDTH];

    // Reduce BLOCK_WIDTH children per node; the lowest valid child wins
    always_comb begin
        for (int l = 0; l <= LEVELS; l++) begin
            lvl_val[l] = '0;
            for (int n = 0; n < VECT_WIDTH; n++) begin
                lvl_ind[l][n] = '0;
            end
        end
        lvl_val[0] = vect_in;
        for (int l = 0; l < LEVELS; l++) begin
            for (int n = 0; n < (VECT_WIDTH >> ((l + 1) * LB)); n++) begin
                // Walk children high to low so the lowest set child is written last
                for (int b = BLOCK_WIDTH - 1; b >= 0; b--) begin
                    if (lvl_val[l][n*BLOCK_WIDTH + b]) begin
                        lvl_val[l+1][n] = 1'b1;
                        lvl_ind[l+1][n] = lvl_ind[l][n*BLOCK_WIDTH + b]
                                        | (VECT_IND_WIDTH'(b) << (l * LB));
                    end
                end
            end
        end
        val_out = lvl_val[LEVELS][0];
        ind_out = lvl_ind[LEVELS][0];
    end

endmodule

// File: rtl/bitmap_iter.sv
// Holds a window bitmap and emits each set bit index (plus base+index) lowest first.
// Latency: first index one cycle after load; one index per cycle; done two cycles after last.
// Backpressure: idx_out/seq_out hold while idx_val & !idx_rdy; load_rdy low until idle.
// Optional flush input enabled by defining BITMAP_ITER_FLUSH_EN.
module bitmap_iter
    import bitmap_iter_pkg::*;
#(
    parameter int VECT_WIDTH     = 64,
    parameter int VECT_IND_WIDTH = 6,
    parameter int BLOCK_WIDTH    = 2,
    parameter int SEQ_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load_val,
    input  logic [VECT_WIDTH-1:0]     load_vect,
    input  logic [SEQ_WIDTH-1:0]      load_base,
    output logic                      load_rdy,
    output logic                      idx_val,
    input  logic                      idx_rdy,
    output logic [VECT_IND_WIDTH-1:0] idx_out,
    output logic [SEQ_WIDTH-1:0]      seq_out,
    output logic                      done
`ifdef BITMAP_ITER_FLUSH_EN
    ,
    input  logic                      flush
`endif
);

    if (VECT_IND_WIDTH != clog2(VECT_WIDTH)) begin : g_ind_chk
        $error("bitmap_iter: VECT_IND_WIDTH must equal log2(VECT_WIDTH)");
    end

    logic [1:0]                state_q, state_d;
    logic [VECT_WIDTH-1:0]     vect_q, vect_d;
    logic [SEQ_WIDTH-1:0]      base_q, base_d;

    logic                      ff_val;
    logic [VECT_IND_WIDTH-1:0] ff_ind;
    logic [VECT_WIDTH-1:0]     clr_mask;
    logic                      in_scan;

    ff_set #(
        .VECT_WIDTH    (VECT_WIDTH),
        .VECT_IND_WIDTH(VECT_IND_WIDTH),
        .BLOCK_WIDTH   (BLOCK_WIDTH)
    ) u_ff_set (
        .vect_in(vect_q),
        .val_out(ff_val),
        .ind_out(ff_ind)
    );

    // One-hot mask of the bit currently presented; only this bit clears on transfer
    assign clr_mask = {{(VECT_WIDTH-1){1'b0}}, 1'b1} << ff_ind;
    assign in_scan  = (state_q == ST_SCAN);

    // Outputs are unregistered; the held bitmap drives them directly
    assign load_rdy = (state_q == ST_IDLE);
    assign idx_val  = in_scan & ff_val;
    assign idx_out  = ff_ind;
    assign seq_out  = base_q + SEQ_WIDTH'(ff_ind);
    assign done     = (state_q == ST_DONE);

    // Next-state logic for the scan FSM and held bitmap/base
    always_comb begin
        state_d = state_q;
        vect_d  = vect_q;
        base_d  = base_q;
        case (state_q)
            ST_IDLE: begin
                if (load_val) begin
                    vect_d  = load_vect;
                    base_d  = load_base;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                // An empty bitmap is only seen after the last transfer has landed,
                // which gives the one idle SCAN cycle before DONE
                if (!ff_val) begin
                    state_d = ST_DONE;
                end else if (idx_rdy) begin
                    vect_d = vect_q & ~clr_mask;
                end
`ifdef BITMAP_ITER_FLUSH_EN
                // Flush wins over a same-cycle transfer; remaining bits are dropped
                if (flush) begin
                    vect_d  = '0;
                    state_d = ST_DONE;
                end
`endif
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, bitmap and base registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            vect_q  <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            vect_q  <= vect_d;
            base_q  <= base_d;
        end
    end

endmodule

// File: tb/tb_bitmap_iter.sv
// Self-checking bench for bitmap_iter: table-driven scans plus hand-written corner sequences.
module tb_bitmap_iter;

    logic        clk;
    logic        rst;
    logic        load_val;
    logic [63:0] load_vect;
    logic [31:0] load_base;
    logic        load_rdy;
    logic        idx_val;
    logic        idx_rdy;
    logic [5:0]  idx_out;
    logic [31:0] seq_out;
    logic        done;
`ifdef BITMAP_ITER_FLUSH_EN
    logic        flush;
`endif

    int checks;
    int errors;

    bitmap_iter #(
        .VECT_WIDTH    (64),
        .VECT_IND_WIDTH(6),
        .BLOCK_WIDTH   (2),
        .SEQ_WIDTH     (32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .load_val (load_val),
        .load_vect(load_vect),
        .load_base(load_base),
        .load_rdy (load_rdy),
        .idx_val  (idx_val),
        .idx_rdy  (idx_rdy),
        .idx_out  (idx_out),
        .seq_out  (seq_out),
        .done     (done)
`ifdef BITMAP_ITER_FLUSH_EN
        ,
        .flush    (flush)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0]      vect;
        logic [31:0]      base;
        logic [2:0]       n;
        logic [3:0][5:0]  idx;
        logic [3:0][31:0] seq;
    } vec_t;

    vec_t tbl [5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && !load_rdy; i++) begin
            step();
        end
        check("wait_load_rdy", 64'(load_rdy), 64'(1'b1));
    endtask

    // Present a load for one cycle; returns at cycle t+1
    task automatic do_load(input logic [63:0] v, input logic [31:0] b);
        load_val  = 1'b1;
        load_vect = v;
        load_base = b;
        step();
        load_val  = 1'b0;
        load_vect = 64'h0;
        load_base = 32'h0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        load_val  = 1'b0;
        load_vect = 64'h0;
        load_base = 32'h0;
        idx_rdy   = 1'b1;
`ifdef BITMAP_ITER_FLUSH_EN
        flush     = 1'b0;
`endif

        tbl[0] = '{vect: 64'h8000_0000_0001_0005, base: 32'd100, n: 3'd4,
                   idx: {6'd63, 6'd16, 6'd2, 6'd0},
                   seq: {32'd163, 32'd116, 32'd102, 32'd100}};
        tbl[1] = '{vect: 64'h0, base: 32'd7, n: 3'd0,
                   idx: '0, seq: '0};
        tbl[2] = '{vect: 64'h20, base: 32'hFFFF_FFFE, n: 3'd1,
                   idx: {6'd0, 6'd0, 6'd0, 6'd5},
                   seq: {32'd0, 32'd0, 32'd0, 32'd3}};
        tbl[3] = '{vect: 64'hC000_0000_0000_0000, base: 32'd0, n: 3'd2,
                   idx: {6'd0, 6'd0, 6'd63, 6'd62},
                   seq: {32'd0, 32'd0, 32'd63, 32'd62}};
        tbl[4] = '{vect: 64'h0000_0001_0000_0100, base: 32'h1000, n: 3'd2,
                   idx: {6'd0, 6'd0, 6'd32, 6'd8},
                   seq: {32'd0, 32'd0, 32'h1020, 32'h1008}};

        // Reset values
        #2;
        check("rst_load_rdy", 64'(load_rdy), 64'(1'b1));
        check("rst_idx_val",  64'(idx_val),  64'(1'b0));
        check("rst_done",     64'(done),     64'(1'b0));
        check("rst_idx_out",  64'(idx_out),  64'(6'd0));
        check("rst_seq_out",  64'(seq_out),  64'(32'd0));
        step();
        rst = 1'b0;
        step();

        // Table-driven scans with continuous idx_rdy
        idx_rdy = 1'b1;
        for (int v = 0; v < 5; v++) begin
            wait_idle();
            do_load(tbl[v].vect, tbl[v].base);
            for (int k = 0; k < int'(tbl[v].n); k++) begin
                check("scan_idx_val", 64'(idx_val), 64'(1'b1));
                check("scan_idx_out", 64'(idx_out), 64'(tbl[v].idx[k]));
                check("scan_seq_out", 64'(seq_out), 64'(tbl[v].seq[k]));
                check("scan_busy",    64'(load_rdy | done), 64'(1'b0));
                step();
            end
            check("tail_idx_val", 64'(idx_val),  64'(1'b0));
            check("tail_done",    64'(done),     64'(1'b0));
            check("tail_rdy",     64'(load_rdy), 64'(1'b0));
            step();
            check("done_pulse",   64'(done),     64'(1'b1));
            check("done_idx_val", 64'(idx_val),  64'(1'b0));
            step();
            check("done_clear",   64'(done),     64'(1'b0));
            check("idle_rdy",     64'(load_rdy), 64'(1'b1));
        end

        // Backpressure: index 0 must hold for five stalled cycles
        wait_idle();
        idx_rdy = 1'b0;
        do_load(64'h3, 32'd50);
        for (int k = 0; k < 5; k++) begin
            check("bp_hold_val", 64'(idx_val), 64'(1'b1));
            check("bp_hold_idx", 64'(idx_out), 64'(6'd0));
            check("bp_hold_seq", 64'(seq_out), 64'(32'd50));
            step();
        end
        idx_rdy = 1'b1;
        check("bp_rel_idx0", 64'(idx_out), 64'(6'd0));
        step();
        check("bp_idx1_val", 64'(idx_val), 64'(1'b1));
        check("bp_idx1",     64'(idx_out), 64'(6'd1));
        check("bp_seq1",     64'(seq_out), 64'(32'd51));
        step();
        check("bp_no_dup",   64'(idx_val), 64'(1'b0));
        step();
        check("bp_done",     64'(done),    64'(1'b1));
        step();

        // Reset in the middle of a scan with bits still held
        wait_idle();
        do_load(64'hF0, 32'd0);
        check("mr_first", 64'(idx_out), 64'(6'd4));
        step();
        check("mr_second", 64'(idx_out), 64'(6'd5));
        rst = 1'b1;
        #1;
        check("mr_rst_rdy",  64'(load_rdy), 64'(1'b1));
        check("mr_rst_val",  64'(idx_val),  64'(1'b0));
        check("mr_rst_done", 64'(done),     64'(1'b0));
        check("mr_rst_idx",  64'(idx_out),  64'(6'd0));
        check("mr_rst_seq",  64'(seq_out),  64'(32'd0));
        step();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("mr_after_rdy", 64'(load_rdy), 64'(1'b1));
            check("mr_after_val", 64'(idx_val),  64'(1'b0));
        end

`ifdef BITMAP_ITER_FLUSH_EN
        // Flush on the second index cycle of an all-ones load
        wait_idle();
        do_load({64{1'b1}}, 32'd0);
        check("fl_idx0", 64'(idx_out), 64'(6'd0));
        step();
        check("fl_idx1", 64'(idx_out), 64'(6'd1));
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("fl_val",  64'(idx_val),  64'(1'b0));
        check("fl_done", 64'(done),     64'(1'b1));
        step();
        check("fl_rdy",  64'(load_rdy), 64'(1'b1));
        check("fl_val2", 64'(idx_val),  64'(1'b0));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bitmap_iter.md
# bitmap_iter

Sequential scanner that accepts a window bitmap (e.g. a SACK or retransmit-needed bitmap), holds it in a register and emits the index of every set bit, lowest first, one per accepted handshake. Each emitted bit is cleared from the held copy. The block feeds its held bitmap to an `ff_set` instance and consumes the `ff_set` result. It sits between the window bitmap state and the per-segment consumer (e.g. the retransmit scheduler).

## Interface
Parameters:
- `VECT_WIDTH`, 64: bitmap width; must be a power of `BLOCK_WIDTH`.
- `VECT_IND_WIDTH`, 6: index width; must equal log2(`VECT_WIDTH`).
- `BLOCK_WIDTH`, 2: fan-in of the `ff_set` tree.
- `SEQ_WIDTH`, 32: width of the sequence base and of the emitted sequence number.

Ports (reset is asynchronous, active-high; single clock domain):
- `clk` in 1: clock.
- `rst` in 1: async active-high reset.
- `load_val` in 1: load request.
- `load_vect` in `VECT_WIDTH`: bitmap to scan.
- `load_base` in `SEQ_WIDTH`: sequence number of bit 0.
- `load_rdy` out 1: block idle, can accept a load.
- `idx_val` out 1: `idx_out`/`seq_out` valid.
- `idx_rdy` in 1: consumer accepts the current index.
- `idx_out` out `VECT_IND_WIDTH`: lowest set bit of the held bitmap.
- `seq_out` out `SEQ_WIDTH`: `base_r + idx_out`, modulo 2^`SEQ_WIDTH`.
- `done` out 1: one-cycle pulse when the scan finishes.
- `flush` in 1: only present with `BITMAP_ITER_FLUSH_EN`.

## Operation
- Registers:
  - `state` ∈ {IDLE, SCAN, DONE}.
  - `vect_r[VECT_WIDTH]`.
  - `base_r[SEQ_WIDTH]`.
- `ff_set` input is `vect_r`. Its `val_out` and `ind_out` are combinational on `vect_r`.
- **IDLE:**
  - `load_rdy`=1, `idx_val`=0.
  - On `load_val`: `vect_r`←`load_vect`, `base_r`←`load_base`, go to SCAN.
- **SCAN:**
  - `idx_val` = `ff_set.val_out`; `idx_out` = `ind_out`; `seq_out` = `base_r` + zero-extended `ind_out`, with the carry dropped.
  - On `idx_val & idx_rdy`: clear `vect_r[idx_out]`; stay in SCAN.
  - If `val_out`=0: go to DONE.
  - `load_val` is ignored (`load_rdy`=0).
- **DONE:** `done`=1 for exactly one cycle, `idx_val`=0, then go to IDLE.
- Handshake rules:
  - While `idx_val`=1 and `idx_rdy`=0, `idx_out` and `seq_out` hold stable.
  - `idx_val` never drops without a transfer, except on `rst` or flush.
- Only one bit is cleared per cycle. Higher set bits are never skipped.
- All-zero load: SCAN lasts one cycle with `idx_val`=0, then DONE.
- `rst` asserted in any state: `state`=IDLE, `vect_r`=0, `base_r`=0 immediately (async).
- Output values under reset: `load_rdy`=1, `idx_val`=0, `done`=0, `idx_out`=0, `seq_out`=0.

## Timing
- Load accepted at edge t (`load_val & load_rdy`). First `idx_val` is visible in cycle t+1.
- One index transfers per cycle under continuous `idx_rdy`. N set bits leave `idx_val` high for N consecutive cycles, t+1..t+N.
- After the last transfer at cycle t+N: SCAN with `idx_val`=0 at t+N+1, `done` at t+N+2, `load_rdy` at t+N+3.
- Back-to-back loads are therefore spaced N+3 cycles apart.
- The combinational path `vect_r` → `ff_set` → `seq_out` adder is one cycle. There is no output register.

## Configuration
- `BITMAP_ITER_FLUSH_EN` defined:
  - The `flush` input exists.
  - `flush`=1 in SCAN clears `vect_r` and forces DONE next cycle, overriding any same-cycle transfer. That transfer still counts as accepted by the consumer, but the bit is not re-emitted.
  - `flush` in IDLE or DONE has no effect.
  - `flush` has priority over `load_val`.
- Undefined: there is no `flush` port, and a scan runs until the bitmap is empty.

## Structure
- Package `bitmap_iter_pkg`:
  - state encoding localparams `ST_IDLE`=2'd0, `ST_SCAN`=2'd1, `ST_DONE`=2'd2.
  - a shared `clog2` function, used to check `VECT_IND_WIDTH`.
- Sub-module: one `ff_set` instance (`VECT_WIDTH`, `VECT_IND_WIDTH`, `BLOCK_WIDTH` passed through).
- Everything else is in the single module: state register, bitmap register with one-hot clear mask, base register, adder.

## Test plan
- **Sparse bitmap:** load `vect`=64'h8000_0000_0001_0005, `base`=100, `idx_rdy`=1.
  - idx 0,2,16,63 and seq 100,102,116,163 on cycles t+1..t+4.
  - `done` at t+6.
- **Empty bitmap:** load 0.
  - `idx_val` never rises.
  - `done` at t+2, `load_rdy` at t+3.
- **Backpressure:** load 64'h3 with `idx_rdy`=0 for 5 cycles.
  - idx 0 held stable for 5 cycles.
  - Then idx 1, then `done`. No duplicates.
- **Sequence wrap:** `base`=32'hFFFF_FFFE, vect bit 5 set.
  - `seq_out`=3.
- **Reset mid-scan:** assert `rst` during SCAN with bits remaining.
  - Outputs go to reset values the same cycle.
  - After release, `load_rdy`=1 and the old bits are never emitted.
- **Flush (`BITMAP_ITER_FLUSH_EN`):** `flush` on the 2nd index cycle of an all-ones load.
  - Next cycle: `idx_val`=0 and `done`=1.
  - Following cycle: `load_rdy`=1.
